// File: rtl/bridge_pkg.sv
// Shared APB-side definitions for the AHB-to-APB bridge and its completer model.
package bridge_pkg;

    localparam int PADDR_SIZE = 32;
    localparam int PDATA_SIZE = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_completer_state_t;

endpackage

// File: rtl/apb_completer_mem_array.sv
// Word-organised storage for the APB completer: byte-strobed synchronous write,
// combinational read, synchronous clear.
module apb_completer_mem_array #(
    parameter int DEPTH      = 16,
    parameter int PDATA_SIZE = 32
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   widx,
    input  logic [PDATA_SIZE/8-1:0]    wstrb,
    input  logic [PDATA_SIZE-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   ridx,
    output logic [PDATA_SIZE-1:0]      rdata
);

    logic [PDATA_SIZE-1:0] mem [DEPTH];

    // NOTE: the array is cleared on reset because reads after reset must return 0;
    // this prevents mapping onto a RAM macro, which is acceptable for a model this small.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < PDATA_SIZE/8; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a byte-strobed word memory with fixed wait states.
// Optional: define APB_COMPLETER_SLVERR_EN to flag out-of-range/misaligned accesses on PSLVERR.
module apb_completer_mem #(
    parameter int PADDR_SIZE  = bridge_pkg::PADDR_SIZE,
    parameter int PDATA_SIZE  = bridge_pkg::PDATA_SIZE,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    pclk,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [2:0]              PPROT,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    import bridge_pkg::*;

    localparam int BYTES = PDATA_SIZE / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    apb_completer_state_t state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PADDR_SIZE-1:0] addr_q;
    logic                  write_q;
    logic [BYTES-1:0]      strb_q;
    logic [PDATA_SIZE-1:0] wdata_q;
    logic                  err_q;

    logic                  pready_d, pslverr_d;
    logic [PDATA_SIZE-1:0] prdata_d;
    logic                  setup, ready_now, mem_we;
    logic                  addr_err, cur_write, cur_err;
    logic [IDX_W-1:0]      rd_idx;
    logic [PDATA_SIZE-1:0] mem_rdata;

    // PPROT carries no meaning for a plain memory target.
    logic unused_pprot;
    assign unused_pprot = ^PPROT;

`ifdef APB_COMPLETER_SLVERR_EN
    assign addr_err = (PADDR >= PADDR_SIZE'(DEPTH * BYTES)) || (PADDR[LSB-1:0] != '0);
`else
    assign addr_err = 1'b0;
`endif

    // With zero wait states the response is produced at the setup edge, before
    // the request has been latched, so the live bus values are used there.
    assign rd_idx    = (state_q == IDLE) ? PADDR[LSB +: IDX_W] : addr_q[LSB +: IDX_W];
    assign cur_write = (state_q == IDLE) ? PWRITE : write_q;
    assign cur_err   = (state_q == IDLE) ? addr_err : err_q;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = PREADY;
        pslverr_d = PSLVERR;
        prdata_d  = PRDATA;
        setup     = 1'b0;
        ready_now = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup     = 1'b1;
                    state_d   = ACCESS;
                    cnt_d     = WAIT_LOAD;
                    ready_now = (WAIT_LOAD == 4'd0);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (PREADY) begin
                    if (PENABLE) begin
                        mem_we    = write_q && !err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    ready_now = (cnt_q <= 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (ready_now) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            prdata_d  = (cur_write || cur_err) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
            if (setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                strb_q  <= PSTRB;
                wdata_q <= PWDATA;
                err_q   <= addr_err;
            end
        end
    end

    apb_completer_mem_array #(
        .DEPTH      (DEPTH),
        .PDATA_SIZE (PDATA_SIZE)
    ) u_array (
        .pclk   (pclk),
        .preset (PRESET),
        .we     (mem_we),
        .widx   (addr_q[LSB +: IDX_W]),
        .wstrb  (strb_q),
        .wdata  (wdata_q),
        .ridx   (rd_idx),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem: zero-wait and 3-wait instances on a shared bus.
module tb_apb_completer_mem;

`ifdef APB_COMPLETER_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = 3'b000;
    logic [3:0]  pstrb = 4'h0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        sel3 = 1'b0;

    logic [31:0] prdata0, prdata3, prdata;
    logic        pready0, pready3, pready, pslverr0, pslverr3, pslverr;
    logic        psel0, psel3;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    assign psel0   = psel && !sel3;
    assign psel3   = psel && sel3;
    assign prdata  = sel3 ? prdata3  : prdata0;
    assign pready  = sel3 ? pready3  : pready0;
    assign pslverr = sel3 ? pslverr3 : pslverr0;

    apb_completer_mem #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PPROT(pprot),
        .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_completer_mem #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut3 (
        .pclk(pclk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PPROT(pprot),
        .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer, starting #1 after a rising edge; leaves the bus idle
    // #1 after the completing edge so a following call is back-to-back.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int waits);
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        while (!pready && waits < 40) begin
            waits++;
            @(posedge pclk); #1;
        end
        if (!pready) begin
            check("pready timeout", {63'd0, pready}, 64'd1);
            psel = 1'b0; penable = 1'b0;
            return;
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        check("outputs cleared after completion", {pready, pslverr, prdata}, 64'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("reset pready0", {63'd0, pready0}, 64'd0);
        check("reset prdata0", {32'd0, prdata0}, 64'd0);
        check("reset pslverr3", {63'd0, pslverr3}, 64'd0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // Zero-wait instance
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
        check("read 0x0 after reset data", {32'd0, rd}, 64'd0);
        check("read 0x0 after reset waits", 64'(wt), 64'd0);
        check("read 0x0 after reset err", {63'd0, er}, 64'd0);

        apb_xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, rd, er, wt);
        check("write 0x4 waits", 64'(wt), 64'd0);
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
        check("read 0x4 data", {32'd0, rd}, 64'hDEAD_BEEF);
        check("read 0x4 waits", 64'(wt), 64'd0);

        apb_xfer(1'b1, 32'h8, 32'h1122_3344, 4'hF, rd, er, wt);
        apb_xfer(1'b1, 32'h8, 32'hAABB_CCDD, 4'h5, rd, er, wt);
        apb_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, er, wt);
        check("strobed merge 0x8", {32'd0, rd}, 64'h11BB_33DD);

        apb_xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, rd, er, wt);
        check("zero-strobe write err", {63'd0, er}, 64'd0);
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
        check("zero-strobe write leaves 0x4", {32'd0, rd}, 64'hDEAD_BEEF);

        // Three-wait instance
        sel3 = 1'b1;
        apb_xfer(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, rd, er, wt);
        check("wait3 write waits", 64'(wt), 64'd3);
        apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
        check("wait3 read 0xC data", {32'd0, rd}, 64'hCAFE_F00D);
        check("wait3 read waits", 64'(wt), 64'd3);

        // Reset asserted in T2 of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("pready low in T2", {63'd0, pready3}, 64'd0);
        preset = 1'b1;
        @(posedge pclk); #1;
        check("mid-transfer reset outputs", {pready3, pslverr3, prdata3}, 64'd0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
        check("0xC after mid-transfer reset", {32'd0, rd}, 64'd0);

        // PSEL dropped during wait states
        apb_xfer(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, rd, er, wt);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0099; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort pready", {63'd0, pready3}, 64'd0);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
        check("abort left 0x10 unchanged", {32'd0, rd}, 64'hA5A5_A5A5);
        check("setup after abort waits", 64'(wt), 64'd3);

        // Out-of-range and misaligned accesses on the zero-wait instance
        sel3 = 1'b0;
        apb_xfer(1'b1, 32'h40, 32'h7777_7777, 4'hF, rd, er, wt);
        check("write 0x40 err", {63'd0, er}, {63'd0, SLV});
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
        check("0x0 after write 0x40", {32'd0, rd}, SLV ? 64'd0 : 64'h7777_7777);
        check("read 0x0 err", {63'd0, er}, 64'd0);
        apb_xfer(1'b1, 32'h2, 32'h1357_9BDF, 4'hF, rd, er, wt);
        check("write 0x2 err", {63'd0, er}, {63'd0, SLV});
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
        check("0x0 after write 0x2", {32'd0, rd}, SLV ? 64'd0 : 64'h1357_9BDF);
        apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, er, wt);
        check("read 0x40 data", {32'd0, rd}, SLV ? 64'd0 : 64'h1357_9BDF);
        check("read 0x40 err", {63'd0, er}, {63'd0, SLV});
        check("read 0x40 waits", 64'(wt), 64'd0);

        repeat (2) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
